lock_sequencer: RTL and testbench

//  Sequencing controller for the code_checker datapath. Turns pushbutton edges into
//  per-digit store/input strobes and a compare strobe, then waits for the result.

---
 rtl/lock_sequencer_pkg.sv | 24 ++
 rtl/lock_sequencer_if.sv | 38 +++
 rtl/lock_timer.sv | 27 ++
 rtl/lock_sequencer.sv | 227 ++++++++++++++++++++++
 tb/tb_lock_sequencer.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lock_sequencer_pkg.sv
// Shared types and helpers for the lock sequencer.
// Holds the FSM state encoding and the counter width helpers.
package lock_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_STORE_ENTRY = 3'd1,
        ST_INPUT_ENTRY = 3'd2,
        ST_COMPARE     = 3'd3,
        ST_WAIT_RESULT = 3'd4,
        ST_UNLOCKED    = 3'd5,
        ST_LOCKOUT     = 3'd6
    } state_t;

    function automatic int cmax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to hold the values 0..n.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/lock_sequencer_if.sv
// Button/result inputs and strobe/status outputs of the lock sequencer.
// master: button and checker side. slave: the sequencer.
interface lock_sequencer_if
    import lock_sequencer_pkg::*;
#(
    parameter int PW_LEN    = 4,
    parameter int MAX_FAILS = 3
);

    logic                           store_btn;
    logic                           input_btn;
    logic                           submit_btn;
    logic                           correct_password;
    logic                           invalid_password;
    logic                           store_value;
    logic                           input_value;
    logic                           input_reset;
    logic                           compare;
    logic                           unlock;
    logic                           sleep;
    logic [cnt_w(PW_LEN)-1:0]       digit_count;
    logic [cnt_w(MAX_FAILS)-1:0]    fail_count;

    modport master (
        output store_btn, input_btn, submit_btn,
        output correct_password, invalid_password,
        input  store_value, input_value, input_reset, compare,
        input  unlock, sleep, digit_count, fail_count
    );

    modport slave (
        input  store_btn, input_btn, submit_btn,
        input  correct_password, invalid_password,
        output store_value, input_value, input_reset, compare,
        output unlock, sleep, digit_count, fail_count
    );

endinterface

// File: rtl/lock_timer.sv
// Loadable down-counter shared by the result, lockout and relock timers.
// Ports: clk, rst (async high), i_load, i_value, o_expired (count is zero).
module lock_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_value,
    output logic         o_expired
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_value;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/lock_sequencer.sv
// Sequencer for the code checker: button edges -> strobes, fail count,
// timed lockout and unlock. Ports: clk, system_reset (async high),
// bus (lock_sequencer_if.slave). Macro LOCK_AUTO_RELOCK_EN enables
// automatic relock after RELOCK_CYCLES without a button edge.
module lock_sequencer
    import lock_sequencer_pkg::*;
#(
    parameter int PW_LEN         = 4,
    parameter int MAX_FAILS      = 3,
    parameter int LOCK_CYCLES    = 50_000_000,
    parameter int RESULT_TIMEOUT = 16,
    parameter int RELOCK_CYCLES  = 250_000_000
) (
    input  logic           clk,
    input  logic           system_reset,
    lock_sequencer_if.slave bus
);

    localparam int DCW = cnt_w(PW_LEN);
    localparam int FCW = cnt_w(MAX_FAILS);
    localparam int TW  = cnt_w(cmax(cmax(LOCK_CYCLES, RESULT_TIMEOUT),
                                    RELOCK_CYCLES));

    localparam logic [DCW-1:0] DC_FULL  = DCW'(PW_LEN);
    localparam logic [FCW-1:0] FC_MAX   = FCW'(MAX_FAILS);
    // Timers load N-1 so the state lasts exactly N cycles.
    localparam logic [TW-1:0]  T_RESULT = TW'(RESULT_TIMEOUT - 1);
    localparam logic [TW-1:0]  T_LOCK   = TW'(LOCK_CYCLES - 1);
    localparam logic [TW-1:0]  T_RELOCK = TW'(RELOCK_CYCLES - 1);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [DCW-1:0] r_dc;
    logic [DCW-1:0] w_dc_nxt;
    logic [FCW-1:0] r_fc;
    logic [FCW-1:0] w_fc_nxt;
    logic [FCW-1:0] w_fc_inc;
    logic           r_pw_set;
    logic           w_pw_set_nxt;

    logic r_sto_q;
    logic r_inp_q;
    logic r_sub_q;
    logic r_sto_edge;
    logic r_inp_edge;
    logic r_sub_edge;

    logic w_sto;
    logic w_inp;
    logic w_sub;
    logic w_fail;

    logic          w_load;
    logic [TW-1:0] w_tval;
    logic          w_expired;

    logic w_store_value;
    logic w_input_value;
    logic w_input_reset;
    logic w_compare;
    logic w_unlock;
    logic w_sleep;

    lock_timer #(
        .W (TW)
    ) u_timer (
        .clk       (clk),
        .rst       (system_reset),
        .i_load    (w_load),
        .i_value   (w_tval),
        .o_expired (w_expired)
    );

    // One winning edge per cycle: submit > input > store.
    assign w_sub = r_sub_edge;
    assign w_inp = r_inp_edge & ~r_sub_edge;
    assign w_sto = r_sto_edge & ~r_inp_edge & ~r_sub_edge;

    assign w_fc_inc = (r_fc == FC_MAX) ? FC_MAX : r_fc + 1'b1;
    // Invalid overrides a simultaneous correct.
    assign w_fail   = bus.invalid_password |
                      (w_expired & ~bus.correct_password);

    always_ff @(posedge clk or posedge system_reset) begin
        if (system_reset) begin
            r_state    <= ST_IDLE;
            r_dc       <= '0;
            r_fc       <= '0;
            r_pw_set   <= 1'b0;
            r_sto_q    <= 1'b0;
            r_inp_q    <= 1'b0;
            r_sub_q    <= 1'b0;
            r_sto_edge <= 1'b0;
            r_inp_edge <= 1'b0;
            r_sub_edge <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_dc       <= w_dc_nxt;
            r_fc       <= w_fc_nxt;
            r_pw_set   <= w_pw_set_nxt;
            r_sto_q    <= bus.store_btn;
            r_inp_q    <= bus.input_btn;
            r_sub_q    <= bus.submit_btn;
            r_sto_edge <= bus.store_btn & ~r_sto_q;
            r_inp_edge <= bus.input_btn & ~r_inp_q;
            r_sub_edge <= bus.submit_btn & ~r_sub_q;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_dc_nxt      = r_dc;
        w_fc_nxt      = r_fc;
        w_pw_set_nxt  = r_pw_set;
        w_store_value = 1'b0;
        w_input_value = 1'b0;
        w_input_reset = 1'b0;
        w_compare     = 1'b0;
        w_unlock      = 1'b0;
        w_sleep       = 1'b0;
        w_load        = 1'b0;
        w_tval        = '0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_inp) begin
                    w_input_reset = 1'b1;
                    w_dc_nxt      = '0;
                    w_state_nxt   = ST_INPUT_ENTRY;
                end else if (w_sto && !r_pw_set) begin
                    // The entering edge is also the first digit.
                    w_store_value = 1'b1;
                    w_dc_nxt      = DCW'(1);
                    w_state_nxt   = ST_STORE_ENTRY;
                end
            end
            ST_STORE_ENTRY: begin
                if (r_dc == DC_FULL) begin
                    w_pw_set_nxt = 1'b1;
                    w_dc_nxt     = '0;
                    w_state_nxt  = ST_IDLE;
                end else if (w_sto) begin
                    w_store_value = 1'b1;
                    w_dc_nxt      = r_dc + 1'b1;
                end
            end
            ST_INPUT_ENTRY: begin
                if (w_sub) begin
                    if (r_dc == DC_FULL) begin
                        w_state_nxt = ST_COMPARE;
                    end else begin
                        w_input_reset = 1'b1;
                        w_dc_nxt      = '0;
                    end
                end else if (w_inp && r_dc < DC_FULL) begin
                    w_input_value = 1'b1;
                    w_dc_nxt      = r_dc + 1'b1;
                end
            end
            ST_COMPARE: begin
                w_compare   = 1'b1;
                w_load      = 1'b1;
                w_tval      = T_RESULT;
                w_state_nxt = ST_WAIT_RESULT;
            end
            ST_WAIT_RESULT: begin
                if (w_fail) begin
                    w_fc_nxt = w_fc_inc;
                    w_dc_nxt = '0;
                    if (w_fc_inc == FC_MAX) begin
                        w_load      = 1'b1;
                        w_tval      = T_LOCK;
                        w_state_nxt = ST_LOCKOUT;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else if (bus.correct_password) begin
                    w_fc_nxt    = '0;
                    w_load      = 1'b1;
                    w_tval      = T_RELOCK;
                    w_state_nxt = ST_UNLOCKED;
                end
            end
            ST_UNLOCKED: begin
                w_unlock = 1'b1;
                if (w_sub) begin
                    w_dc_nxt    = '0;
                    w_state_nxt = ST_IDLE;
                end else if (w_sto) begin
                    w_store_value = 1'b1;
                    w_dc_nxt      = DCW'(1);
                    w_state_nxt   = ST_STORE_ENTRY;
                end
`ifdef LOCK_AUTO_RELOCK_EN
                else if (w_inp) begin
                    w_load = 1'b1;
                    w_tval = T_RELOCK;
                end else if (w_expired) begin
                    w_dc_nxt    = '0;
                    w_state_nxt = ST_IDLE;
                end
`else
`endif
            end
            ST_LOCKOUT: begin
                w_sleep = 1'b1;
                if (w_expired) begin
                    w_fc_nxt    = '0;
                    w_dc_nxt    = '0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.store_value = w_store_value;
    assign bus.input_value = w_input_value;
    assign bus.input_reset = w_input_reset;
    assign bus.compare     = w_compare;
    assign bus.unlock      = w_unlock;
    assign bus.sleep       = w_sleep;
    assign bus.digit_count = r_dc;
    assign bus.fail_count  = r_fc;

endmodule

// File: tb/tb_lock_sequencer.sv
// Directed self-checking bench for lock_sequencer.
// Small timer values keep lockout and relock runs short.
module tb_lock_sequencer;

    localparam int PW_LEN         = 4;
    localparam int MAX_FAILS      = 3;
    localparam int LOCK_CYCLES    = 20;
    localparam int RESULT_TIMEOUT = 8;
    localparam int RELOCK_CYCLES  = 30;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   n_strb = 0;

    always #5 clk = ~clk;

    lock_sequencer_if #(
        .PW_LEN    (PW_LEN),
        .MAX_FAILS (MAX_FAILS)
    ) bus ();

    lock_sequencer #(
        .PW_LEN         (PW_LEN),
        .MAX_FAILS      (MAX_FAILS),
        .LOCK_CYCLES    (LOCK_CYCLES),
        .RESULT_TIMEOUT (RESULT_TIMEOUT),
        .RELOCK_CYCLES  (RELOCK_CYCLES)
    ) dut (
        .clk          (clk),
        .system_reset (rst),
        .bus          (bus.slave)
    );

    always @(negedge clk) begin
        if (!rst) begin
            n_strb += int'(bus.store_value) + int'(bus.input_value)
                    + int'(bus.input_reset) + int'(bus.compare);
            checks++;
            if ($countones({bus.store_value, bus.input_value,
                            bus.input_reset, bus.compare}) > 1) begin
                errors++;
                $display("FAIL strobe_mutex got %b%b%b%b want one-hot",
                         bus.store_value, bus.input_value,
                         bus.input_reset, bus.compare);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One press of the chosen buttons; strb = {store,input,reset,compare}
    // seen in the strobe cycle. Returns just after the state update.
    task automatic press(input logic s, input logic i, input logic u,
                         output logic [3:0] strb);
        bus.store_btn  = s;
        bus.input_btn  = i;
        bus.submit_btn = u;
        tick();
        bus.store_btn  = 1'b0;
        bus.input_btn  = 1'b0;
        bus.submit_btn = 1'b0;
        @(negedge clk);
        strb = {bus.store_value, bus.input_value,
                bus.input_reset, bus.compare};
        tick();
    endtask

    // Full entry from IDLE; returns in the COMPARE cycle.
    task automatic attempt();
        logic [3:0] s;
        press(1'b0, 1'b1, 1'b0, s);
        repeat (PW_LEN) press(1'b0, 1'b1, 1'b0, s);
        press(1'b0, 1'b0, 1'b1, s);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if (bus.unlock !== 1'b0) begin
            errors++;
            $display("FAIL rst_unlock got %b want 0", bus.unlock);
        end
        checks++;
        if (bus.sleep !== 1'b0) begin
            errors++;
            $display("FAIL rst_sleep got %b want 0", bus.sleep);
        end
        checks++;
        if ({bus.store_value, bus.input_value, bus.input_reset,
             bus.compare} !== 4'b0000) begin
            errors++;
            $display("FAIL rst_strobes got %b%b%b%b want 0000",
                     bus.store_value, bus.input_value,
                     bus.input_reset, bus.compare);
        end
        checks++;
        if (bus.digit_count !== 3'd0) begin
            errors++;
            $display("FAIL rst_dc got %0d want 0", bus.digit_count);
        end
        checks++;
        if (bus.fail_count !== 2'd0) begin
            errors++;
            $display("FAIL rst_fc got %0d want 0", bus.fail_count);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_store();
        logic [3:0] s;
        for (int k = 1; k <= PW_LEN; k++) begin
            press(1'b1, 1'b0, 1'b0, s);
            checks++;
            if (s !== 4'b1000) begin
                errors++;
                $display("FAIL store_strb%0d got %b want 1000", k, s);
            end
            checks++;
            if (bus.digit_count !== 3'(k)) begin
                errors++;
                $display("FAIL store_dc%0d got %0d want %0d",
                         k, bus.digit_count, k);
            end
        end
        tick();
        checks++;
        if (bus.digit_count !== 3'd0) begin
            errors++;
            $display("FAIL store_done_dc got %0d want 0", bus.digit_count);
        end
        press(1'b1, 1'b0, 1'b0, s);
        checks++;
        if (s !== 4'b0000) begin
            errors++;
            $display("FAIL store_5th got %b want 0000", s);
        end
    endtask

    task automatic test_input_correct();
        logic [3:0] s;
        press(1'b0, 1'b1, 1'b0, s);
        checks++;
        if (s !== 4'b0010 || bus.digit_count !== 3'd0) begin
            errors++;
            $display("FAIL in_enter got %b dc %0d want 0010 dc 0",
                     s, bus.digit_count);
        end
        for (int k = 1; k <= PW_LEN; k++) begin
            press(1'b0, 1'b1, 1'b0, s);
            checks++;
            if (s !== 4'b0100 || bus.digit_count !== 3'(k)) begin
                errors++;
                $display("FAIL in_digit%0d got %b dc %0d want 0100 dc %0d",
                         k, s, bus.digit_count, k);
            end
        end
        press(1'b0, 1'b0, 1'b1, s);
        checks++;
        if (bus.compare !== 1'b1) begin
            errors++;
            $display("FAIL in_compare got %b want 1", bus.compare);
        end
        tick();
        checks++;
        if (bus.compare !== 1'b0) begin
            errors++;
            $display("FAIL in_compare_1cyc got %b want 0", bus.compare);
        end
        tick();
        tick();
        bus.correct_password = 1'b1;
        tick();
        bus.correct_password = 1'b0;
        checks++;
        if (bus.unlock !== 1'b1 || bus.fail_count !== 2'd0) begin
            errors++;
            $display("FAIL in_unlock got %b fc %0d want 1 fc 0",
                     bus.unlock, bus.fail_count);
        end
`ifndef LOCK_AUTO_RELOCK_EN
        repeat (40) tick();
        checks++;
        if (bus.unlock !== 1'b1) begin
            errors++;
            $display("FAIL unlock_hold got %b want 1", bus.unlock);
        end
`endif
        press(1'b0, 1'b0, 1'b1, s);
        checks++;
        if (bus.unlock !== 1'b0 || s !== 4'b0000) begin
            errors++;
            $display("FAIL relock_submit got %b strb %b want 0 0000",
                     bus.unlock, s);
        end
    endtask

    task automatic test_lockout();
        int n;
        int base;
        for (int a = 1; a <= MAX_FAILS; a++) begin
            attempt();
            tick();
            bus.invalid_password = 1'b1;
            tick();
            bus.invalid_password = 1'b0;
            checks++;
            if (bus.fail_count !== 2'(a) || bus.sleep !== (a == MAX_FAILS))
            begin
                errors++;
                $display("FAIL lock_fc%0d got fc %0d sleep %b", a,
                         bus.fail_count, bus.sleep);
            end
        end
        base = n_strb;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            bus.store_btn  = (i == 2);
            bus.input_btn  = (i == 5);
            bus.submit_btn = (i == 8);
            @(negedge clk);
            if (!bus.sleep) break;
            n++;
            @(posedge clk);
            #1;
        end
        bus.store_btn  = 1'b0;
        bus.input_btn  = 1'b0;
        bus.submit_btn = 1'b0;
        tick();
        checks++;
        if (n != LOCK_CYCLES) begin
            errors++;
            $display("FAIL lock_len got %0d want %0d", n, LOCK_CYCLES);
        end
        checks++;
        if (n_strb != base) begin
            errors++;
            $display("FAIL lock_ignore got %0d strobes want 0",
                     n_strb - base);
        end
        checks++;
        if (bus.fail_count !== 2'd0 || bus.sleep !== 1'b0) begin
            errors++;
            $display("FAIL lock_exit got fc %0d sleep %b want 0 0",
                     bus.fail_count, bus.sleep);
        end
    endtask

    task automatic test_early_submit_timeout();
        logic [3:0] s;
        int w;
        press(1'b0, 1'b1, 1'b0, s);
        press(1'b0, 1'b1, 1'b0, s);
        press(1'b0, 1'b1, 1'b0, s);
        press(1'b0, 1'b0, 1'b1, s);
        checks++;
        if (s !== 4'b0010 || bus.digit_count !== 3'd0 ||
            bus.compare !== 1'b0) begin
            errors++;
            $display("FAIL early_sub got %b dc %0d cmp %b want 0010 0 0",
                     s, bus.digit_count, bus.compare);
        end
        repeat (PW_LEN) press(1'b0, 1'b1, 1'b0, s);
        press(1'b0, 1'b0, 1'b1, s);
        checks++;
        if (bus.compare !== 1'b1) begin
            errors++;
            $display("FAIL to_compare got %b want 1", bus.compare);
        end
        w = 0;
        while (bus.fail_count !== 2'd1 && w < 50) begin
            tick();
            w++;
        end
        checks++;
        if (w != RESULT_TIMEOUT + 1) begin
            errors++;
            $display("FAIL timeout_len got %0d want %0d",
                     w, RESULT_TIMEOUT + 1);
        end
    endtask

    task automatic test_both_results();
        attempt();
        tick();
        bus.correct_password = 1'b1;
        bus.invalid_password = 1'b1;
        tick();
        bus.correct_password = 1'b0;
        bus.invalid_password = 1'b0;
        checks++;
        if (bus.fail_count !== 2'd2 || bus.unlock !== 1'b0) begin
            errors++;
            $display("FAIL both_res got fc %0d unlock %b want 2 0",
                     bus.fail_count, bus.unlock);
        end
    endtask

    task automatic test_priority();
        logic [3:0] s;
        press(1'b0, 1'b1, 1'b0, s);
        press(1'b0, 1'b1, 1'b0, s);
        press(1'b1, 1'b1, 1'b1, s);
        checks++;
        if (s !== 4'b0010 || bus.digit_count !== 3'd0) begin
            errors++;
            $display("FAIL prio got %b dc %0d want 0010 dc 0",
                     s, bus.digit_count);
        end
        repeat (PW_LEN) press(1'b0, 1'b1, 1'b0, s);
        press(1'b0, 1'b0, 1'b1, s);
        tick();
        bus.invalid_password = 1'b1;
        tick();
        bus.invalid_password = 1'b0;
        checks++;
        if (bus.fail_count !== 2'd3 || bus.sleep !== 1'b1) begin
            errors++;
            $display("FAIL third_fail got fc %0d sleep %b want 3 1",
                     bus.fail_count, bus.sleep);
        end
    endtask

    task automatic test_reset_mid_lockout();
        logic [3:0] s;
        repeat (5) tick();
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.sleep !== 1'b0 || bus.fail_count !== 2'd0 ||
            bus.digit_count !== 3'd0 || bus.unlock !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst got sleep %b fc %0d dc %0d unlock %b",
                     bus.sleep, bus.fail_count, bus.digit_count,
                     bus.unlock);
        end
        tick();
        rst = 1'b0;
        tick();
        press(1'b1, 1'b0, 1'b0, s);
        checks++;
        if (s !== 4'b1000 || bus.digit_count !== 3'd1) begin
            errors++;
            $display("FAIL pw_cleared got %b dc %0d want 1000 dc 1",
                     s, bus.digit_count);
        end
        repeat (PW_LEN - 1) press(1'b1, 1'b0, 1'b0, s);
        tick();
    endtask

`ifdef LOCK_AUTO_RELOCK_EN
    task automatic test_relock();
        int n;
        attempt();
        tick();
        bus.correct_password = 1'b1;
        tick();
        bus.correct_password = 1'b0;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!bus.unlock) break;
            n++;
        end
        tick();
        checks++;
        if (n != RELOCK_CYCLES) begin
            errors++;
            $display("FAIL relock_len got %0d want %0d", n, RELOCK_CYCLES);
        end
    endtask
`endif

    initial begin
        bus.store_btn        = 1'b0;
        bus.input_btn        = 1'b0;
        bus.submit_btn       = 1'b0;
        bus.correct_password = 1'b0;
        bus.invalid_password = 1'b0;
        test_reset();
        test_store();
        test_input_correct();
        test_lockout();
        test_early_submit_timeout();
        test_both_results();
        test_priority();
        test_reset_mid_lockout();
`ifdef LOCK_AUTO_RELOCK_EN
        test_relock();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
